// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared state encoding and default widths for the tone scheduler.
// Revision : 1.0
// ============================================================================
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int c_tick_div = 100000;
  localparam int c_div_w    = 17;
  localparam int c_dur_w    = 16;

endpackage
`default_nettype wire

// File: rtl/tone_divider.sv
`default_nettype none
// ============================================================================
// Module   : tone_divider
// Purpose  : Square-wave toggle counter; toggles every half_period+1 enabled cycles.
// Revision : 1.0
// ============================================================================
module tone_divider
  import audio_pkg::*;
#(
  parameter int DIV_W = c_div_w
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_half_period,
  output logic             o_audio
);

  logic [DIV_W-1:0] r_hp;
  logic [DIV_W-1:0] r_cnt;
  logic             r_audio;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hp    <= '0;
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else begin
      if (i_load) begin
        r_hp <= i_half_period;
      end
      if (i_clear) begin
        r_cnt   <= '0;
        r_audio <= 1'b0;
      end else if (i_enable) begin
        if (r_cnt == r_hp) begin
          r_cnt <= '0;
          // A zero half-period is a rest: keep counting time but stay silent.
          if (r_hp != '0) begin
            r_audio <= ~r_audio;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_audio = r_audio;

endmodule
`default_nettype wire

// File: rtl/audio_tone_sched.sv
`default_nettype none
// ============================================================================
// Module   : audio_tone_sched
// Purpose  : Round-robin scheduler sharing one tone generator among NREQ
//            requesters. Optional build macro PRIORITY_PREEMPT_EN lets a rising
//            req[0] preempt any other playing note.
// Revision : 1.0
// ============================================================================
module audio_tone_sched
  import audio_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DIV_W     = c_div_w,
  parameter int DUR_W     = c_dur_w,
  parameter int TICK_DIV  = c_tick_div,
  parameter int GAP_TICKS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] half_period,
  input  logic [NREQ*DUR_W-1:0] duration,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  audio_out
);

  localparam int c_idx_w   = $clog2(NREQ);
  localparam int c_sum_w   = c_idx_w + 1;
  localparam int c_presc_w = $clog2(TICK_DIV + 1);
  localparam logic [c_presc_w-1:0] c_tick_max = c_presc_w'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]     c_gap      = DUR_W'(GAP_TICKS);
  localparam state_t c_post_state = (GAP_TICKS == 0) ? IDLE : GAP;

  state_t                 r_state,     w_state_nxt;
  logic [c_idx_w-1:0]     r_winner,    w_winner_nxt;
  logic [c_idx_w-1:0]     r_last,      w_last_nxt;
  logic [NREQ-1:0]        r_grant,     w_grant_nxt;
  logic [NREQ-1:0]        r_done,      w_done_nxt;
  logic [c_presc_w-1:0]   r_presc,     w_presc_nxt;
  logic [DUR_W-1:0]       r_remaining, w_remaining_nxt;

  logic                   w_div_en;
  logic                   w_div_load;
  logic                   w_div_clear;
  logic                   w_found;
  logic [c_idx_w-1:0]     w_pick;
  logic [c_sum_w-1:0]     w_sum;
  logic                   w_tick;
  logic                   w_preempt;
  logic [NREQ-1:0]        w_onehot;
  logic [DUR_W-1:0]       w_dur_sel;
  logic [DIV_W-1:0]       w_hp_sel;

  assign w_tick    = (r_presc == c_tick_max);
  assign w_onehot  = NREQ'(1) << r_winner;
  assign w_dur_sel = duration[int'(r_winner)*DUR_W +: DUR_W];
  assign w_hp_sel  = half_period[int'(r_winner)*DIV_W +: DIV_W];

`ifdef PRIORITY_PREEMPT_EN
  logic r_req0_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req0_d <= 1'b0;
    end else begin
      r_req0_d <= req[0];
    end
  end

  assign w_preempt = req[0] && !r_req0_d && (r_winner != '0);
`else
  assign w_preempt = 1'b0;
`endif

  // Round-robin search starting just after the last granted index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_sum = {1'b0, r_last} + c_sum_w'(i);
      if (w_sum >= c_sum_w'(NREQ)) begin
        w_sum = w_sum - c_sum_w'(NREQ);
      end
      if (!w_found && req[w_sum[c_idx_w-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[c_idx_w-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_winner    <= '0;
      r_last      <= c_idx_w'(NREQ - 1);
      r_grant     <= '0;
      r_done      <= '0;
      r_presc     <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_winner    <= w_winner_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_presc     <= w_presc_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_winner_nxt    = r_winner;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_done_nxt      = '0;
    w_presc_nxt     = '0;
    w_remaining_nxt = r_remaining;
    w_div_en        = 1'b0;
    w_div_load      = 1'b0;
    w_div_clear     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = LOAD;
          w_winner_nxt = w_pick;
        end
      end
      LOAD: begin
        w_last_nxt  = r_winner;
        w_div_load  = 1'b1;
        w_div_clear = 1'b1;
        if (w_dur_sel == '0) begin
          w_done_nxt      = w_onehot;
          w_grant_nxt     = '0;
          w_remaining_nxt = c_gap;
          w_state_nxt     = c_post_state;
        end else begin
          w_grant_nxt     = w_onehot;
          w_remaining_nxt = w_dur_sel;
          w_state_nxt     = PLAY;
        end
      end
      PLAY: begin
        w_div_en    = 1'b1;
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_preempt) begin
          w_state_nxt  = LOAD;
          w_winner_nxt = '0;
          w_grant_nxt  = '0;
          w_div_clear  = 1'b1;
          w_presc_nxt  = '0;
        end else if (!req[r_winner]) begin
          w_grant_nxt     = '0;
          w_div_clear     = 1'b1;
          w_remaining_nxt = c_gap;
          w_presc_nxt     = '0;
          w_state_nxt     = c_post_state;
        end else if (w_tick) begin
          if (r_remaining == DUR_W'(1)) begin
            w_done_nxt      = w_onehot;
            w_grant_nxt     = '0;
            w_div_clear     = 1'b1;
            w_remaining_nxt = c_gap;
            w_presc_nxt     = '0;
            w_state_nxt     = c_post_state;
          end else begin
            w_remaining_nxt = r_remaining - 1'b1;
          end
        end
      end
      GAP: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          if (r_remaining <= DUR_W'(1)) begin
            w_state_nxt = IDLE;
          end else begin
            w_remaining_nxt = r_remaining - 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  tone_divider #(
    .DIV_W (DIV_W)
  ) u_tone_divider (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (w_div_en),
    .i_clear       (w_div_clear),
    .i_load        (w_div_load),
    .i_half_period (w_hp_sel),
    .o_audio       (audio_out)
  );

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire
